// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: byte-wide instruction port toward the memory controller,
// IF/ID output toward decode, and stall/redirect controls from later stages.
interface if_fetch_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              stall_i;
   logic              redirect_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              mem_req_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_done_i;
   logic [7:0]        mem_data_i;
   logic              valid_o;
   logic [ADDR_W-1:0] pc_o;
   logic [31:0]       inst_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, mem_done_i, mem_data_i,
      output mem_req_o, mem_addr_o, valid_o, pc_o, inst_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, mem_done_i, mem_data_i,
      input  mem_req_o, mem_addr_o, valid_o, pc_o, inst_o
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC and assembles each 32-bit instruction from four
// little-endian byte reads, then holds it for decode until accepted or redirected.
module if_fetch #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst,
   if_fetch_if.master bus
);
   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state;
   logic [1:0]        k;
   logic [ADDR_W-1:0] pc;
   logic [23:0]       asm_buf;
   logic              valid_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       inst_q;

   // Request is gated by rst so it reads zero during reset and rises right after release.
   assign bus.mem_req_o  = rst && (state == FETCH);
   assign bus.mem_addr_o = rst ? (pc + ADDR_W'(k)) : ADDR_W'(0);
   assign bus.valid_o    = valid_q;
   assign bus.pc_o       = pc_q;
   assign bus.inst_o     = inst_q;

   // Redirect outranks byte completion and acceptance; lane 3 goes straight to the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= FETCH;
         k       <= 2'd0;
         pc      <= RESET_PC;
         asm_buf <= 24'h0;
         valid_q <= 1'b0;
         pc_q    <= ADDR_W'(0);
         inst_q  <= 32'h0;
      end else if (bus.redirect_i) begin
         state   <= FETCH;
         k       <= 2'd0;
         pc      <= bus.redirect_pc_i;
         valid_q <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (bus.mem_done_i) begin
                  if (k == 2'd3) begin
                     inst_q  <= {bus.mem_data_i, asm_buf};
                     pc_q    <= pc;
                     valid_q <= 1'b1;
                     state   <= HOLD;
                  end else begin
                     case (k)
                        2'd0:    asm_buf[7:0]   <= bus.mem_data_i;
                        2'd1:    asm_buf[15:8]  <= bus.mem_data_i;
                        default: asm_buf[23:16] <= bus.mem_data_i;
                     endcase
                     k <= k + 2'd1;
                  end
               end
            end
            HOLD: begin
               if (!bus.stall_i) begin
                  pc      <= pc + ADDR_W'(4);
                  k       <= 2'd0;
                  state   <= FETCH;
                  valid_q <= 1'b0;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte memory responder, scoreboard of delivered
// instructions, and inline checks of addresses, stall hold, redirect and reset.
module tb_if_fetch;
   localparam int unsigned ADDR_W = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   if_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   if_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [logic [31:0]];
   exp_t        exp_q [$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   bit          random_mode = 1'b0;
   int          wait_cnt = 0;
   bit          armed = 1'b0;
   bit          prev_wait = 1'b0;
   bit          prev_redir = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
   endtask

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   task automatic push(input logic [31:0] p, input logic [31:0] w);
      exp_q.push_back(exp_t'{pc: p, inst: w});
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         cyc();
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_valid(input int max);
      int n = 0;
      cyc();
      while (bus.valid_o !== 1'b1 && n < max) begin
         cyc();
         n++;
      end
      if (bus.valid_o !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL valid_timeout: got valid=%b expected 1", bus.valid_o);
      end
   endtask

   // Memory responder: byte from the presented address after 0 or 0..7 wait cycles;
   // spurious done with junk data whenever no request is up.
   initial begin : responder
      bus.mem_done_i = 1'b0;
      bus.mem_data_i = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            armed = 1'b0;
            prev_wait = 1'b0;
            bus.mem_done_i = 1'b0;
         end else if (bus.mem_req_o) begin
            if (prev_wait && !prev_redir) chk("addr_stable", bus.mem_addr_o, prev_addr);
            if (!armed) begin
               wait_cnt = random_mode ? int'($urandom_range(7, 0)) : 0;
               armed = 1'b1;
            end
            if (wait_cnt == 0) begin
               bus.mem_done_i = 1'b1;
               bus.mem_data_i = mem_rd(bus.mem_addr_o);
               armed = 1'b0;
               prev_wait = 1'b0;
            end else begin
               wait_cnt--;
               bus.mem_done_i = 1'b0;
               bus.mem_data_i = 8'h5A;
               prev_wait = 1'b1;
            end
            prev_addr = bus.mem_addr_o;
            prev_redir = bus.redirect_i;
         end else begin
            bus.mem_done_i = 1'b1;
            bus.mem_data_i = 8'hEE;
            prev_wait = 1'b0;
         end
      end
   end

   // Scoreboard monitor: compares each instruction at the edge decode accepts it.
   initial begin : monitor
      forever begin
         @(negedge clk);
         #3;
         if (rst && bus.valid_o === 1'b1 && !bus.stall_i && !bus.redirect_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_inst: got pc=%h inst=%h expected none", bus.pc_o, bus.inst_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_pc", bus.pc_o, mon_e.pc);
               chk("sb_inst", bus.inst_o, mon_e.inst);
            end
         end
      end
   end

   initial begin : stim
      int n;
      set_word(32'h000, 32'h0000_0013);
      set_word(32'h004, 32'h00A0_0093);
      set_word(32'h008, 32'h0041_0113);
      set_word(32'h00C, 32'h0010_0073);
      set_word(32'h100, 32'h0000_12B7);
      set_word(32'h104, 32'h0400_00EF);
      set_word(32'h200, 32'h0000_8067);
      set_word(32'h204, 32'h0000_0513);
      bus.stall_i = 1'b0;
      bus.redirect_i = 1'b0;
      bus.redirect_pc_i = 32'h0;
      rst = 1'b0;

      repeat (3) cyc();
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_pc", bus.pc_o, 0);
      chk("rst_inst", bus.inst_o, 0);
      chk("rst_req", bus.mem_req_o, 0);
      chk("rst_addr", bus.mem_addr_o, 0);

      // First fetch: bytes 13,00,00,00 from address 0, zero wait.
      push(32'h0, 32'h0000_0013);
      rst = 1'b1;
      #2;
      chk("req_b0", bus.mem_req_o, 1);
      chk("addr_b0", bus.mem_addr_o, 32'h0);
      cyc(); chk("addr_b1", bus.mem_addr_o, 32'h1);
      cyc(); chk("addr_b2", bus.mem_addr_o, 32'h2);
      cyc(); chk("addr_b3", bus.mem_addr_o, 32'h3);
      cyc();
      chk("hold_valid", bus.valid_o, 1);
      chk("hold_req", bus.mem_req_o, 0);

      // Stall three cycles in HOLD: everything frozen.
      bus.stall_i = 1'b1;
      repeat (3) begin
         cyc();
         chk("stall_valid", bus.valid_o, 1);
         chk("stall_inst", bus.inst_o, 32'h0000_0013);
         chk("stall_pc", bus.pc_o, 32'h0);
         chk("stall_req", bus.mem_req_o, 0);
      end
      bus.stall_i = 1'b0;
      cyc();
      chk("next_addr", bus.mem_addr_o, 32'h4);
      chk("next_valid", bus.valid_o, 0);
      chk("next_req", bus.mem_req_o, 1);

      // Stall outside HOLD has no effect.
      bus.stall_i = 1'b1;
      cyc(); chk("fstall_addr", bus.mem_addr_o, 32'h5);
      cyc(); chk("fstall_addr2", bus.mem_addr_o, 32'h6);

      // Redirect in FETCH(2) with a completing byte: byte dropped, restart at 0x100.
      bus.stall_i = 1'b0;
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'h100;
      push(32'h100, 32'h0000_12B7);
      cyc();
      bus.redirect_i = 1'b0;
      chk("redir_addr", bus.mem_addr_o, 32'h100);
      chk("redir_valid", bus.valid_o, 0);
      drain(20);

      // Redirect in HOLD with no stall: instruction at 0x104 is never delivered.
      wait_valid(20);
      chk("hold104_pc", bus.pc_o, 32'h104);
      chk("hold104_inst", bus.inst_o, 32'h0400_00EF);
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'h200;
      push(32'h200, 32'h0000_8067);
      cyc();
      bus.redirect_i = 1'b0;
      chk("hredir_valid", bus.valid_o, 0);
      chk("hredir_addr", bus.mem_addr_o, 32'h200);
      drain(20);
      chk("after200_addr", bus.mem_addr_o, 32'h204);

      // Random 0..7 wait per byte: same instruction stream from address 0.
      random_mode = 1'b1;
      bus.redirect_i = 1'b1;
      bus.redirect_pc_i = 32'h0;
      push(32'h0, 32'h0000_0013);
      push(32'h4, 32'h00A0_0093);
      push(32'h8, 32'h0041_0113);
      cyc();
      bus.redirect_i = 1'b0;
      drain(400);
      random_mode = 1'b0;

      // Asynchronous reset in FETCH(2) of 0xC.
      n = 0;
      while (!(bus.mem_req_o === 1'b1 && bus.mem_addr_o === 32'hE) && n < 80) begin
         cyc();
         n++;
      end
      chk("reach_fetch2", bus.mem_addr_o, 32'hE);
      rst = 1'b0;
      #1;
      chk("arst_valid", bus.valid_o, 0);
      chk("arst_pc", bus.pc_o, 0);
      chk("arst_inst", bus.inst_o, 0);
      chk("arst_req", bus.mem_req_o, 0);
      chk("arst_addr", bus.mem_addr_o, 0);
      push(32'h0, 32'h0000_0013);
      cyc();
      cyc();
      rst = 1'b1;
      #2;
      chk("rel_req", bus.mem_req_o, 1);
      chk("rel_addr", bus.mem_addr_o, 32'h0);
      drain(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
